voice_allocator: RTL and testbench

Command-driven voice allocator and scheduler for the four-channel signed mixer. It accepts note-on/note-off commands over a valid/ready handshake and assigns each note to one of four voices. It drives the mixer's four frequency inputs, where a frequency of 0 mutes that channel. When all four voices are busy, it steals the least-recently-allocated voice.

---
 rtl/voice_allocator_pkg.sv | 14 +
 rtl/voice_allocator_if.sv | 9 +
 rtl/voice_allocator_lru.sv | 30 +++
 rtl/voice_allocator.sv | 113 +++++++++++
 tb/tb_voice_allocator.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared constants, FSM/action enums and a priority helper for the voice allocator
package voice_allocator_pkg;
   localparam int NUM_VOICES = 4;
   localparam int DEF_FREQ_W = 8;
   localparam int RANK_W = 2;
   typedef enum logic [1:0] {IDLE, DECIDE, WRITE} state_t;
   typedef enum logic [2:0] {ACT_NOP, ACT_RETRIG, ACT_ALLOC, ACT_STEAL, ACT_CLEAR} act_t;
   // Index of the lowest set bit; zero when nothing is set.
   function automatic logic [RANK_W-1:0] first_set(input logic [NUM_VOICES-1:0] v);
      first_set = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--)
         if (v[i]) first_set = RANK_W'(i);
   endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note command valid/ready channel between a command source and the allocator
interface voice_allocator_if #(parameter int FREQ_W = voice_allocator_pkg::DEF_FREQ_W);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_on;
   logic [FREQ_W-1:0] cmd_freq;
   modport master (output cmd_valid, cmd_on, cmd_freq, input cmd_ready);
   modport slave (input cmd_valid, cmd_on, cmd_freq, output cmd_ready);
endinterface

// File: rtl/voice_allocator_lru.sv
// voice_lru: least-recently-allocated ranking of the four voices (rank 0 newest, rank 3 oldest)
module voice_lru
   import voice_allocator_pkg::*;
(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                clear,
   input  logic                                touch,
   input  logic                                rel,
   input  logic [RANK_W-1:0]                   idx,
   output logic [RANK_W-1:0]                   oldest,
   output logic [NUM_VOICES-1:0][RANK_W-1:0]   rank
);
   // Touch moves a voice to newest, release moves it to oldest; others shift to keep a permutation.
   always_ff @(posedge clk)
      if (reset || clear)
         for (int i = 0; i < NUM_VOICES; i++) rank[i] <= RANK_W'(i);
      else if (touch)
         for (int i = 0; i < NUM_VOICES; i++)
            rank[i] <= (RANK_W'(i) == idx) ? '0 : (rank[i] < rank[idx]) ? rank[i] + 1'b1 : rank[i];
      else if (rel)
         for (int i = 0; i < NUM_VOICES; i++)
            rank[i] <= (RANK_W'(i) == idx) ? '1 : (rank[i] > rank[idx]) ? rank[i] - 1'b1 : rank[i];
   // The oldest voice is the one holding the maximum rank.
   always_comb begin
      oldest = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         if (rank[i] == '1) oldest = RANK_W'(i);
   end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/off commands to four mixer voices, stealing the oldest when full
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int FREQ_W = DEF_FREQ_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   panic,
   voice_allocator_if.slave       cmd,
   output logic [FREQ_W-1:0]      freq1,
   output logic [FREQ_W-1:0]      freq2,
   output logic [FREQ_W-1:0]      freq3,
   output logic [FREQ_W-1:0]      freq4,
   output logic [NUM_VOICES-1:0]  voice_active,
   output logic                   steal_pulse
);
   state_t                                 state, state_nx;
   act_t                                   act, act_nx;
   logic                                   on_q, hs, write_en, touch, rel;
   logic [FREQ_W-1:0]                      freq_q;
   logic [NUM_VOICES-1:0][FREQ_W-1:0]      voice;
   logic [NUM_VOICES-1:0]                  match, idle, seen;
   logic [RANK_W-1:0]                      tgt, tgt_nx, oldest;
   logic [NUM_VOICES-1:0][RANK_W-1:0]      rank;

   voice_lru u_lru (
      .clk    (clk),
      .reset  (reset),
      .clear  (panic),
      .touch  (touch),
      .rel    (rel),
      .idx    (tgt),
      .oldest (oldest),
      .rank   (rank)
   );

   assign hs = cmd.cmd_valid && cmd.cmd_ready;

   // State register; panic aborts any command in flight.
   always_ff @(posedge clk)
      state <= (reset || panic) ? IDLE : state_nx;

   // Next state: one command walks IDLE -> DECIDE -> WRITE -> IDLE.
   always_comb
      state_nx = (state == IDLE) ? (hs ? DECIDE : IDLE) : (state == DECIDE) ? WRITE : IDLE;

   // Outputs decoded from state; ready is also withheld while reset or panic is asserted.
   always_comb begin
      cmd.cmd_ready = (state == IDLE) && !reset && !panic;
      write_en = (state == WRITE);
      touch = write_en && (act inside {ACT_RETRIG, ACT_ALLOC, ACT_STEAL});
      rel = write_en && (act == ACT_CLEAR);
   end

   // Latch the accepted command; the source only holds it until the handshake.
   always_ff @(posedge clk)
      if (hs) begin
         on_q <= cmd.cmd_on;
         freq_q <= cmd.cmd_freq;
      end

   // Match/idle comparators and the note rules, in priority order.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         match[i] = (voice[i] == freq_q) && (|freq_q);
         idle[i] = ~|voice[i];
      end
      act_nx = !on_q ? (|match ? ACT_CLEAR : ACT_NOP) :
               ~|freq_q ? ACT_NOP : |match ? ACT_RETRIG : |idle ? ACT_ALLOC : ACT_STEAL;
      tgt_nx = |match ? first_set(match) : |idle ? first_set(idle) : oldest;
   end

   // Register the decision so WRITE works from stable target/action.
   always_ff @(posedge clk)
      if (reset || panic) begin
         act <= ACT_NOP;
         tgt <= '0;
      end else if (state == DECIDE) begin
         act <= act_nx;
         tgt <= tgt_nx;
      end

   // Frequency registers and the steal strobe, updated in WRITE.
   always_ff @(posedge clk)
      if (reset || panic) begin
         voice <= '0;
         steal_pulse <= 1'b0;
      end else begin
         steal_pulse <= write_en && (act == ACT_STEAL);
         if (write_en && (act inside {ACT_ALLOC, ACT_STEAL})) voice[tgt] <= freq_q;
         else if (rel) voice[tgt] <= '0;
      end

   // A voice is active whenever it holds a nonzero frequency.
   always_comb
      for (int i = 0; i < NUM_VOICES; i++) voice_active[i] = |voice[i];

   assign freq1 = voice[0];
   assign freq2 = voice[1];
   assign freq3 = voice[2];
   assign freq4 = voice[3];

   // Ranks must stay a permutation of 0..3, otherwise steals would pick the wrong voice.
   always_comb begin
      seen = '0;
      for (int i = 0; i < NUM_VOICES; i++) seen[rank[i]] = 1'b1;
   end

   // Flag a broken rank permutation in simulation.
   always_ff @(posedge clk)
      if (!reset) assert (&seen);
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench with a queue-based LRU reference model and random commands
module tb_voice_allocator;
   typedef struct {
      logic [31:0] pre;
      logic [31:0] post;
      logic        st;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       panic = 1'b0;
   logic [7:0] freq1, freq2, freq3, freq4;
   logic [3:0] voice_active;
   logic       steal_pulse;
   int         total = 0;
   int         bad = 0;
   exp_t       sb[$];
   logic [7:0] mf[4];
   int         order[$];
   bit         p1 = 0, p2 = 0, c1, c2;
   exp_t       e_mon;

   voice_allocator_if #(.FREQ_W(8)) cmd ();

   voice_allocator #(.FREQ_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .panic        (panic),
      .cmd          (cmd.slave),
      .freq1        (freq1),
      .freq2        (freq2),
      .freq3        (freq3),
      .freq4        (freq4),
      .voice_active (voice_active),
      .steal_pulse  (steal_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] outs();
      return {freq4, freq3, freq2, freq1};
   endfunction

   function automatic logic [31:0] mpack();
      return {mf[3], mf[2], mf[1], mf[0]};
   endfunction

   function automatic logic [3:0] act_of(input logic [31:0] v);
      logic [3:0] a;
      for (int i = 0; i < 4; i++) a[i] = (v[8*i +: 8] != 8'h00);
      return a;
   endfunction

   // order holds voice indices oldest first.
   function automatic void m_move(input int v, input bit newest);
      for (int i = 0; i < order.size(); i++)
         if (order[i] == v) begin
            order.delete(i);
            break;
         end
      if (newest) order.push_back(v);
      else order.push_front(v);
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) mf[i] = 8'h00;
      order = '{3, 2, 1, 0};
   endfunction

   function automatic bit m_apply(input bit on, input logic [7:0] f);
      int k = -1;
      for (int i = 0; i < 4; i++) if (f != 0 && mf[i] == f && k < 0) k = i;
      if (on) begin
         if (f == 0) return 0;
         if (k >= 0) begin
            m_move(k, 1);
            return 0;
         end
         for (int i = 0; i < 4; i++)
            if (mf[i] == 0) begin
               mf[i] = f;
               m_move(i, 1);
               return 0;
            end
         k = order[0];
         mf[k] = f;
         m_move(k, 1);
         return 1;
      end
      for (int i = 0; i < 4; i++)
         if (f != 0 && mf[i] == f) begin
            mf[i] = 8'h00;
            m_move(i, 0);
         end
      return 0;
   endfunction

   task automatic send(input bit on, input logic [7:0] f);
      exp_t e;
      int w = 0;
      while (!cmd.cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!cmd.cmd_ready) begin
         chk("ready_timeout", {31'd0, cmd.cmd_ready}, 32'd1);
         return;
      end
      e.pre = mpack();
      e.st = m_apply(on, f);
      e.post = mpack();
      sb.push_back(e);
      cmd.cmd_valid = 1'b1;
      cmd.cmd_on = on;
      cmd.cmd_freq = f;
      @(negedge clk);
      cmd.cmd_valid = 1'b0;
      cmd.cmd_freq = 8'($urandom);
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   task automatic ready_gap();
      chk("busy_decide", {31'd0, cmd.cmd_ready}, 32'd0);
      @(negedge clk);
      chk("busy_write", {31'd0, cmd.cmd_ready}, 32'd0);
      @(negedge clk);
      chk("ready_back", {31'd0, cmd.cmd_ready}, 32'd1);
   endtask

   task automatic do_panic();
      panic = 1'b1;
      #1 chk("ready_in_panic", {31'd0, cmd.cmd_ready}, 32'd0);
      @(negedge clk);
      panic = 1'b0;
      m_reset();
      #1 chk("panic_outs", outs(), 32'd0);
      chk("panic_ready", {31'd0, cmd.cmd_ready}, 32'd1);
   endtask

   task automatic abort(input bit use_reset);
      cmd.cmd_valid = 1'b1;
      cmd.cmd_on = 1'b1;
      cmd.cmd_freq = 8'h42;
      @(negedge clk);
      cmd.cmd_valid = 1'b0;
      if (use_reset) reset = 1'b1;
      else panic = 1'b1;
      #1 chk("abort_ready_low", {31'd0, cmd.cmd_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      panic = 1'b0;
      m_reset();
      #1 chk("abort_outs", outs(), 32'd0);
      chk("abort_active", {28'd0, voice_active}, 32'd0);
      chk("abort_ready", {31'd0, cmd.cmd_ready}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("abort_no_42", outs(), 32'd0);
      end
   endtask

   // Monitor: outputs must hold one cycle after the handshake and update on the second.
   initial begin
      forever begin
         @(posedge clk);
         c1 = p1;
         c2 = p2;
         if (reset || panic) begin
            p1 = 0;
            p2 = 0;
         end else begin
            p2 = p1;
            p1 = cmd.cmd_valid && cmd.cmd_ready;
            #1;
            if (c1) begin
               if (sb.size() > 0) chk("hold_pre", outs(), sb[0].pre);
               else chk("sb_underflow", sb.size(), 32'd1);
            end
            if (c2) begin
               if (sb.size() > 0) begin
                  e_mon = sb.pop_front();
                  chk("freq", outs(), e_mon.post);
                  chk("active", {28'd0, voice_active}, {28'd0, act_of(e_mon.post)});
                  chk("steal", {31'd0, steal_pulse}, {31'd0, e_mon.st});
               end else chk("sb_underflow", sb.size(), 32'd1);
            end else chk("steal_idle", {31'd0, steal_pulse}, 32'd0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      cmd.cmd_valid = 1'b0;
      cmd.cmd_on = 1'b0;
      cmd.cmd_freq = 8'h00;
      m_reset();
      repeat (3) @(negedge clk);
      chk("ready_in_reset", {31'd0, cmd.cmd_ready}, 32'd0);
      chk("reset_outs", outs(), 32'd0);
      chk("reset_active", {28'd0, voice_active}, 32'd0);
      chk("reset_steal", {31'd0, steal_pulse}, 32'd0);
      reset = 1'b0;
      #1 chk("ready_after_reset", {31'd0, cmd.cmd_ready}, 32'd1);

      send(1, 8'h40);
      send(1, 8'h50);
      settle();
      chk("t1_freq1", {24'd0, freq1}, 32'h40);
      chk("t1_freq2", {24'd0, freq2}, 32'h50);
      chk("t1_active", {28'd0, voice_active}, 32'b0011);
      do_panic();

      foreach (sb[i]) ;
      send(1, 8'h10); send(1, 8'h20); send(1, 8'h30); send(1, 8'h40);
      send(1, 8'h55);
      settle();
      chk("t2_steal_freq1", {24'd0, freq1}, 32'h55);
      send(1, 8'h66);
      settle();
      chk("t2_steal_freq2", {24'd0, freq2}, 32'h66);
      do_panic();

      send(1, 8'h10); send(1, 8'h20); send(1, 8'h30); send(1, 8'h40);
      send(1, 8'h10);
      send(1, 8'h77);
      settle();
      chk("t3_freq2", {24'd0, freq2}, 32'h77);
      chk("t3_freq1", {24'd0, freq1}, 32'h10);
      do_panic();

      send(1, 8'h10); send(1, 8'h20); send(1, 8'h30);
      send(0, 8'h20);
      send(1, 8'h99);
      settle();
      chk("t4_freq2", {24'd0, freq2}, 32'h99);
      send(0, 8'h33);
      settle();
      chk("t4_noop_off", outs(), 32'h00309910);

      send(1, 8'h00);
      ready_gap();
      send(0, 8'h00);
      ready_gap();
      chk("t5_zero_noop", outs(), 32'h00309910);
      do_panic();

      send(1, 8'h10); send(1, 8'h20);
      settle();
      abort(0);
      send(1, 8'h10); send(1, 8'h20);
      settle();
      abort(1);

      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 29) == 0) begin
            settle();
            do_panic();
         end
         send($urandom_range(0, 9) < 7, 8'($urandom_range(0, 7) * 8'h11));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      settle();
      @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
